// File: rtl/sad_cand_gen.sv
// Vertical-search SAD candidate generator: stores an 8x8 current block, then streams
// reference rows and accumulates all 16 candidate SADs in parallel for compare_tree.
module sad_cand_gen #(
    parameter int PIX_W    = 8,
    parameter int BLK      = 8,
    parameter int NUM_CAND = 16,
    parameter int SAD_W    = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BLK*PIX_W-1:0]      in_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CAND*SAD_W-1:0] sad_out
);

    localparam int NUM_REF = BLK + NUM_CAND - 1;
    localparam int CNT_W   = $clog2(NUM_REF);
    localparam int RI_W    = $clog2(BLK);
    localparam int RS_W    = $clog2(BLK * ((1 << PIX_W) - 1) + 1);

    typedef enum logic [1:0] {
        LOAD_CUR,
        STREAM_REF,
        OUT
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic                    running;
    logic                    accept;
    logic [BLK*PIX_W-1:0]    cur [BLK];
    logic [SAD_W-1:0]        acc [NUM_CAND];
    logic [RS_W-1:0]         row_sad [BLK];
    logic [SAD_W-1:0]        acc_sum [NUM_CAND];
    logic                    acc_hit [NUM_CAND];

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // in_ready stays low until the first edge after reset has been seen
    assign in_ready  = running && (state != OUT);
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready;

    always_comb begin
        for (int r = 0; r < BLK; r++) begin
            row_sad[r] = '0;
            for (int i = 0; i < BLK; i++) begin
                row_sad[r] = row_sad[r] + RS_W'(abs_diff(cur[r][i*PIX_W +: PIX_W],
                                                         in_row[i*PIX_W +: PIX_W]));
            end
        end
    end

    // Reference row k feeds candidate y through current row r = k - y when 0 <= r < BLK
    always_comb begin
        for (int y = 0; y < NUM_CAND; y++) begin
            logic [CNT_W:0] d;
            d          = {1'b0, cnt} - (CNT_W+1)'(y);
            acc_hit[y] = (d < (CNT_W+1)'(BLK));
            acc_sum[y] = acc[y] + SAD_W'(row_sad[d[RI_W-1:0]]);
        end
    end

    always_comb begin
        for (int y = 0; y < NUM_CAND; y++) begin
            sad_out[y*SAD_W +: SAD_W] = acc[y];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD_CUR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            LOAD_CUR: begin
                if (accept) begin
                    if (cnt == CNT_W'(BLK - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = STREAM_REF;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            STREAM_REF: begin
                if (accept) begin
                    if (cnt == CNT_W'(NUM_REF - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = OUT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = LOAD_CUR;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = LOAD_CUR;
            end
        endcase
    end

    // Accumulators clear on the handshake so the result stays held throughout OUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            for (int r = 0; r < BLK; r++) begin
                cur[r] <= '0;
            end
            for (int y = 0; y < NUM_CAND; y++) begin
                acc[y] <= '0;
            end
        end else begin
            running <= 1'b1;
            if (state == LOAD_CUR && accept) begin
                cur[cnt[RI_W-1:0]] <= in_row;
            end
            if (state == STREAM_REF && accept) begin
                for (int y = 0; y < NUM_CAND; y++) begin
                    if (acc_hit[y]) begin
                        acc[y] <= acc_sum[y];
                    end
                end
            end
            if (state == OUT && out_ready) begin
                for (int y = 0; y < NUM_CAND; y++) begin
                    acc[y] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_cand_gen.sv
// Directed self-checking bench for sad_cand_gen: ramp, max magnitude, exact match,
// backpressure with bubbles, and reset behaviour.
module tb_sad_cand_gen;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_row;
    logic         out_valid;
    logic         out_ready;
    logic [223:0] sad_out;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [63:0]  cur_rows [8];
    logic [63:0]  ref_rows [23];
    logic [223:0] exp_vec;

    sad_cand_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sad_out   (sad_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [223:0] observed,
                               input logic [223:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic logic [63:0] fill(input logic [7:0] b);
        return {8{b}};
    endfunction

    function automatic logic [223:0] ramp_vec();
        logic [223:0] v;
        v = '0;
        for (int y = 0; y < 16; y++) v[y*14 +: 14] = 14'(64 * y + 224);
        return v;
    endfunction

    function automatic logic [223:0] const_vec(input int val);
        logic [223:0] v;
        v = '0;
        for (int y = 0; y < 16; y++) v[y*14 +: 14] = 14'(val);
        return v;
    endfunction

    // Reference model: direct SAD of the 8x8 block at vertical offset y
    function automatic logic [223:0] model();
        logic [223:0] v;
        int s, a, b;
        v = '0;
        for (int y = 0; y < 16; y++) begin
            s = 0;
            for (int r = 0; r < 8; r++) begin
                for (int i = 0; i < 8; i++) begin
                    a = int'(cur_rows[r][i*8 +: 8]);
                    b = int'(ref_rows[y+r][i*8 +: 8]);
                    s += (a > b) ? (a - b) : (b - a);
                end
            end
            v[y*14 +: 14] = 14'(s);
        end
        return v;
    endfunction

    task automatic set_ramp();
        for (int r = 0; r < 8; r++) cur_rows[r] = fill(8'h00);
        for (int k = 0; k < 23; k++) ref_rows[k] = fill(8'(k));
    endtask

    task automatic set_max();
        for (int r = 0; r < 8; r++) cur_rows[r] = fill(8'hFF);
        for (int k = 0; k < 23; k++) ref_rows[k] = fill(8'h00);
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted
    task automatic applyStimulus(input logic [63:0] row);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_row   = row;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("accept_timeout", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_row   = fill(8'h5A);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_block(input bit gaps, input int first);
        for (int n = first; n < 8; n++) begin
            if (gaps) idle($urandom_range(0, 2));
            applyStimulus(cur_rows[n]);
        end
        for (int k = 0; k < 23; k++) begin
            if (gaps) idle($urandom_range(0, 2));
            if (k == 22) checkOutput("valid_before_last", out_valid, 0);
            applyStimulus(ref_rows[k]);
        end
        checkOutput("valid_after_last", out_valid, 1);
    endtask

    task automatic finishBlock(input string tag, input logic [223:0] expected);
        checkOutput({tag, "_sad"}, sad_out, expected);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, out_valid, 0);
        checkOutput({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int zeros, best_y, best_sad;

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_row    = '1;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_sad_out", sad_out, 0);
        rst = 1'b0;
        checkOutput("release_in_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("post_release_in_ready", in_ready, 1);

        $display("[TB] ramp block");
        set_ramp();
        run_block(1'b0, 0);
        finishBlock("ramp", ramp_vec());

        $display("[TB] max magnitude block");
        set_max();
        run_block(1'b0, 0);
        finishBlock("max", const_vec(16320));

        $display("[TB] exact match block");
        for (int r = 0; r < 8; r++) cur_rows[r] = fill(8'(10 * r + 1));
        for (int k = 0; k < 23; k++)
            ref_rows[k] = (k >= 5 && k <= 12) ? fill(8'(10 * (k - 5) + 1)) : fill(8'd200);
        run_block(1'b0, 0);
        checkOutput("match_sad5", sad_out[5*14 +: 14], 0);
        zeros    = 0;
        best_y   = 0;
        best_sad = int'(sad_out[13:0]);
        for (int y = 0; y < 16; y++) begin
            if (sad_out[y*14 +: 14] == 14'd0) zeros++;
            if (int'(sad_out[y*14 +: 14]) < best_sad) begin
                best_sad = int'(sad_out[y*14 +: 14]);
                best_y   = y;
            end
        end
        checkOutput("match_zero_count", zeros, 1);
        checkOutput("match_best_y", best_y, 5);
        checkOutput("match_best_sad", best_sad, 0);
        finishBlock("match", model());

        $display("[TB] backpressure and bubbles");
        set_ramp();
        run_block(1'b1, 0);
        in_valid = 1'b1;
        in_row   = fill(8'hAA);
        for (int c = 0; c < 10; c++) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_ready", in_ready, 0);
            checkOutput("stall_sad", sad_out, ramp_vec());
            @(negedge clk);
        end
        set_max();
        in_row    = cur_rows[0];
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("handoff_valid_drop", out_valid, 0);
        checkOutput("handoff_in_ready", in_ready, 1);
        checkOutput("handoff_sad_clear", sad_out, 0);
        applyStimulus(cur_rows[0]);
        run_block(1'b0, 1);
        finishBlock("after_stall", const_vec(16320));

        $display("[TB] mid-block reset");
        set_ramp();
        for (int n = 0; n < 8; n++) applyStimulus(cur_rows[n]);
        for (int k = 0; k < 7; k++) applyStimulus(ref_rows[k]);
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_sad_out", sad_out, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_block(1'b0, 0);
        finishBlock("ramp_after_rst", ramp_vec());

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/sad_cand_gen.md
Name: sad_cand_gen

Overview:
- Produces the 16 candidate SADs consumed by compare_tree for an 8x8 current block over a vertical search range of 16 offsets (motion_vec_y 0..15).
- Input is a row stream: 8 current-block rows, then 23 reference-window rows.
- Each reference row is compared against all 8 stored current rows in one cycle, and the result accumulates into per-candidate SAD registers.
- Sits between the pixel fetch logic and compare_tree, and presents one flat 16x14-bit SAD vector per block with a valid/ready handshake.

Parameters:
- PIX_W, 8, pixel width in bits.
- BLK, 8, block edge in pixels (rows and pixels per row).
- NUM_CAND, 16, number of vertical candidates; reference rows per block = BLK+NUM_CAND-1 = 23.
- SAD_W, 14, accumulator width. Must satisfy 2^SAD_W > BLK*BLK*(2^PIX_W-1); 16320 < 16384 at the defaults.

Ports:
- clk, in, 1, clock; all state changes on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- in_valid, in, 1, in_row holds a valid row.
- in_ready, out, 1, block accepts a row this cycle.
- in_row, in, BLK*PIX_W (64), one row of pixels; pixel i is at bits [8i+7:8i].
- out_valid, out, 1, sad_out holds a complete candidate set.
- out_ready, in, 1, downstream (compare_tree stage) accepts sad_out.
- sad_out, out, NUM_CAND*SAD_W (224), candidate y SAD at bits [14y+13:14y]. Candidate y corresponds to sad_y / motion_vec_y=y at compare_tree.

Behaviour:
- Reset (asynchronous, any cycle, including mid-block):
  - state=LOAD_CUR, row counter=0.
  - All 16 accumulators and all 8 current-row registers = 0.
  - out_valid=0, sad_out=0.
  - in_ready=1 from the first clock edge after rst deasserts. in_ready is 0 while rst is high.
- An input beat is accepted on a rising edge when in_valid && in_ready.
- The row counter advances only on accepted beats. in_valid bubbles have no effect.
- States:
  - LOAD_CUR (in_ready=1): beat n (0..7) stores in_row into cur[n]. Accumulators are cleared on entry. After beat 7: counter=0, go to STREAM_REF.
  - STREAM_REF (in_ready=1): beat k (0..22) is reference row k. For every r in 0..7 with y=k-r in 0..15, acc[y] += sum over i of |cur[r][i] - ref[i]|. Up to 8 accumulators update in the same cycle; pairs with y outside 0..15 are ignored. After beat 22: go to OUT.
  - OUT (in_ready=0, out_valid=1): sad_out = acc, held stable until out_ready. On out_valid && out_ready: out_valid=0 next cycle, go to LOAD_CUR, counter=0.
- Absolute difference is unsigned 8-bit |a-b|.
- Row partial sum is 11 bits (max 2040). Accumulators are unsigned SAD_W bits and cannot overflow; no saturation logic.
- Final acc[y] = sum over r=0..7 of rowSAD(cur[r], ref[y+r]).
- Latency: out_valid rises on the edge that accepts ref beat 22, so it is visible the cycle after that beat is presented.
- Handshake rules:
  - No input is accepted in the cycle the output handshake completes.
  - in_ready returns to 1 the following cycle.
  - Back-to-back blocks therefore cost 31 accepted beats + 1 output cycle minimum.
- out_valid never drops without out_ready. sad_out changes only in LOAD_CUR/STREAM_REF or on reset.
- in_row is ignored when in_ready=0, regardless of in_valid.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, sad_out=0, in_ready=0 during reset; in_ready=1 after release, no beat counted during reset.
- Ramp: cur rows all 0x00; ref row k all bytes = k (k=0..22) -> sad_y = 64y+224 (sad_0=224, sad_15=1184). out_valid appears exactly after the 31st accepted beat.
- Max magnitude: cur all 0xFF, ref all 0x00 -> all 16 SADs = 16320, no wrap.
- Exact match at y=5:
  - Stimulus: cur row r bytes = 10r+1; ref row k = 10(k-5)+1 for k=5..12, 200 elsewhere.
  - Response: sad_5=0, all other SADs > 0; compare_tree fed with sad_out reports motion_vec_y=5, sad_cmp=0.
- Backpressure and bubbles:
  - Stimulus: random in_valid gaps during load/stream; out_ready low 10 cycles.
  - Response: result identical to the gap-free run; sad_out and out_valid stable while stalled; in_ready=0 throughout OUT.
  - The next block is accepted starting the cycle after the output handshake.
- Mid-block reset: assert rst after 15 accepted beats -> out_valid=0, sad_out=0 immediately. A subsequent full ramp block yields the same values as the ramp test.
